antisat_lock_pipe: RTL and testbench

//  Parametrised, pipelined Anti-SAT locking stage. It replaces the fixed 5-input,

---
 rtl/antisat_pkg.sv | 19 +
 rtl/antisat_key_loader.sv | 47 ++++
 rtl/antisat_lock_pipe.sv | 105 ++++++++++
 tb/tb_antisat_lock_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/antisat_pkg.sv
// Shared types and helpers for the Anti-SAT locking stage.
// The FSM state encoding, the default key length and an AND-reduce helper live here.
package antisat_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  localparam int N_IN_DEF = 4;
  localparam int KEY_W    = 2 * N_IN_DEF;

  // Callers pad unused upper bits with ones so they do not affect the result.
  function automatic logic g_and(input logic [31:0] vec);
    return &vec;
  endfunction

endpackage

// File: rtl/antisat_key_loader.sv
// Serial key loader: EMPTY -> LOAD -> ARMED FSM, bit index and key register.
// Bits are written LSB first; key_start restarts a load from any state.
module antisat_key_loader
  import antisat_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_start,
  input  logic              i_key_bit,
  input  logic              i_key_valid,
  output logic [2*N_IN-1:0] o_key_q,
  output logic              o_key_loaded,
  output state_t            o_state
);

  localparam int KW    = 2 * N_IN;
  localparam int IDX_W = $clog2(KW);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [KW-1:0]     r_key_q;

  // Reset key is deliberately wrong: K1 all-ones, K2 all-zeros.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_idx   <= '0;
      r_key_q <= {{N_IN{1'b0}}, {N_IN{1'b1}}};
    end else if (i_key_start) begin
      r_state <= ST_LOAD;
      r_idx   <= '0;
    end else if ((r_state == ST_LOAD) && i_key_valid) begin
      r_key_q[r_idx] <= i_key_bit;
      r_idx          <= r_idx + IDX_W'(1);
      if (r_idx == IDX_W'(KW - 1)) begin
        r_state <= ST_ARMED;
      end
    end
  end

  assign o_key_q      = r_key_q;
  assign o_key_loaded = (r_state == ST_ARMED);
  assign o_state      = r_state;

endmodule

// File: rtl/antisat_lock_pipe.sv
// Pipelined Anti-SAT locking stage: two valid/ready stages that XOR-flip the
// protected outputs with Y, plus a saturating count of corrupted beats.
module antisat_lock_pipe
  import antisat_pkg::*;
#(
  parameter int                N_IN      = 4,
  parameter int                N_OUT     = 2,
  parameter logic [N_OUT-1:0]  FLIP_MASK = {N_OUT{1'b1}},
  parameter int                CNT_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_start,
  input  logic              i_key_bit,
  input  logic              i_key_valid,
  output logic              o_key_loaded,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [N_IN-1:0]   i_x_in,
  input  logic [N_OUT-1:0]  i_prot_in,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [N_OUT-1:0]  o_data_out,
  output logic [CNT_W-1:0]  o_flip_cnt,
  output state_t            o_dbg_state
);

  logic [2*N_IN-1:0] w_key_q;
  logic              w_armed;
  logic [N_IN-1:0]   w_k1;
  logic [N_IN-1:0]   w_k2;
  logic              w_y;
  logic              w_accept;
  logic              w_s2_load;
  logic              w_out_fire;

  logic [N_IN-1:0]   r_x1;
  logic [N_OUT-1:0]  r_prot1;
  logic              r_v1;
  logic              r_v2;
  logic [N_OUT-1:0]  r_dout;
  logic [CNT_W-1:0]  r_cnt;

  antisat_key_loader #(.N_IN(N_IN)) u_key_loader (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_key_start  (i_key_start),
    .i_key_bit    (i_key_bit),
    .i_key_valid  (i_key_valid),
    .o_key_q      (w_key_q),
    .o_key_loaded (o_key_loaded),
    .o_state      (o_dbg_state)
  );

  assign w_armed = (o_dbg_state == ST_ARMED);
  assign w_k1    = w_key_q[N_IN-1:0];
  assign w_k2    = w_key_q[2*N_IN-1:N_IN];

  // Y = &(x1^K1) & ~&(x1^K2); upper pad is ones so only N_IN bits matter (N_IN < 32).
  assign w_y = g_and({{(32-N_IN){1'b1}}, r_x1 ^ w_k1}) &
               ~g_and({{(32-N_IN){1'b1}}, r_x1 ^ w_k2});

  // Handshake: a beat moves on an edge where valid & ready are both high;
  // valid never depends on ready, and a held beat keeps its data stable.
  assign o_in_ready  = w_armed & (~r_v1 | ~r_v2 | i_out_ready);
  assign o_out_valid = w_armed & r_v2;
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_s2_load   = w_armed & r_v1 & (~r_v2 | i_out_ready);
  assign w_out_fire  = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x1    <= '0;
      r_prot1 <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_dout  <= '0;
      r_cnt   <= '0;
    end else if (i_key_start) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x1    <= i_x_in;
        r_prot1 <= i_prot_in;
        r_v1    <= 1'b1;
      end else if (w_s2_load) begin
        r_v1 <= 1'b0;
      end
      if (w_s2_load) begin
        r_dout <= r_prot1 ^ ({N_OUT{w_y}} & FLIP_MASK);
        r_v2   <= 1'b1;
        if (w_y && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_out_fire) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign o_data_out = r_dout;
  assign o_flip_cnt = r_cnt;

endmodule

// File: tb/tb_antisat_lock_pipe.sv
// Directed bench for antisat_lock_pipe with an output scoreboard; a second
// instance with a 2-bit counter covers saturation.
module tb_antisat_lock_pipe;
  import antisat_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_key_start;
  logic       i_key_bit;
  logic       i_key_valid;
  logic       i_in_valid;
  logic [3:0] i_x_in;
  logic [1:0] i_prot_in;
  logic       i_out_ready;

  logic       o_key_loaded, o_in_ready, o_out_valid;
  logic [1:0] o_data_out;
  logic [7:0] o_flip_cnt;
  state_t     o_dbg_state;

  logic       s_key_loaded, s_in_ready, s_out_valid;
  logic [1:0] s_data_out;
  logic [1:0] s_flip_cnt;
  state_t     s_dbg_state;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         chk_lat  = 1'b0;
  logic [3:0] tb_k1, tb_k2;
  logic [1:0] last_out = '0;
  logic [1:0] exp_q[$];
  int         acc_q[$];

  antisat_lock_pipe #(.N_IN(4), .N_OUT(2), .FLIP_MASK(2'b11), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_key_start(i_key_start), .i_key_bit(i_key_bit),
    .i_key_valid(i_key_valid), .o_key_loaded(o_key_loaded), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .i_x_in(i_x_in), .i_prot_in(i_prot_in),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_data_out(o_data_out),
    .o_flip_cnt(o_flip_cnt), .o_dbg_state(o_dbg_state)
  );

  antisat_lock_pipe #(.N_IN(4), .N_OUT(2), .FLIP_MASK(2'b11), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst(i_rst), .i_key_start(i_key_start), .i_key_bit(i_key_bit),
    .i_key_valid(i_key_valid), .o_key_loaded(s_key_loaded), .i_in_valid(i_in_valid),
    .o_in_ready(s_in_ready), .i_x_in(i_x_in), .i_prot_in(i_prot_in),
    .o_out_valid(s_out_valid), .i_out_ready(i_out_ready), .o_data_out(s_data_out),
    .o_flip_cnt(s_flip_cnt), .o_dbg_state(s_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model(input logic [3:0] x, input logic [1:0] p);
    logic y;
    y = ((x ^ tb_k1) == 4'hF) && ((x ^ tb_k2) != 4'hF);
    return p ^ (y ? 2'b11 : 2'b00);
  endfunction

  // scoreboard: push on accepted input, pop and compare on output transfer
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_when_empty", o_out_valid, 1'b0);
        end else begin
          logic [1:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("dout", o_data_out, e);
          last_out = o_data_out;
          if (chk_lat) check("latency", cyc - a, 2);
        end
      end
      if (i_in_valid && o_in_ready && !i_key_start) begin
        exp_q.push_back(model(i_x_in, i_prot_in));
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] k, input bit clash);
    i_key_start = 1'b1;
    i_key_valid = clash;
    i_key_bit   = 1'b1;
    exp_q.delete();
    acc_q.delete();
    step();
    i_key_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_key_valid = 1'b1;
      i_key_bit   = k[i];
      if (i == 7) check("loaded_before_last", o_key_loaded, 1'b0);
      step();
    end
    i_key_valid = 1'b0;
    tb_k1 = k[3:0];
    tb_k2 = k[7:4];
    check("loaded_after_last", o_key_loaded, 1'b1);
  endtask

  task automatic send(input logic [3:0] x, input logic [1:0] p);
    bit done;
    done = 1'b0;
    i_in_valid = 1'b1;
    i_x_in     = x;
    i_prot_in  = p;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (o_in_ready) begin
        step();
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", o_in_ready, 1'b1);
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    i_rst = 1'b1; i_key_start = 1'b0; i_key_bit = 1'b0; i_key_valid = 1'b0;
    i_in_valid = 1'b1; i_x_in = '0; i_prot_in = '0; i_out_ready = 1'b1;
    tb_k1 = 4'hF; tb_k2 = 4'h0;

    // 1: reset
    step(); step();
    check("rst_in_ready", o_in_ready, 1'b0);
    check("rst_out_valid", o_out_valid, 1'b0);
    check("rst_flip_cnt", o_flip_cnt, 8'd0);
    check("rst_key_loaded", o_key_loaded, 1'b0);
    check("rst_state", o_dbg_state, 2'd0);
    check("rst_sat_in_ready", s_in_ready, 1'b0);
    check("rst_sat_out_valid", s_out_valid, 1'b0);
    check("rst_sat_state", s_dbg_state, 2'd0);
    i_rst = 1'b0;
    step();
    check("empty_in_ready", o_in_ready, 1'b0);
    i_in_valid = 1'b0;

    // 2: correct key, 1 beat/cycle, latency 2
    load_key(8'hAA, 1'b0);
    check("armed_state", o_dbg_state, 2'd2);
    chk_lat = 1'b1;
    for (int x = 0; x < 16; x++) send(4'(x), 2'b01);
    i_in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    check("t2_last_out", last_out, 2'b01);
    check("t2_flip_cnt", o_flip_cnt, 8'd0);

    // 3: wrong key K1=0, K2=F
    load_key(8'hF0, 1'b0);
    send(4'hF, 2'b01);
    i_in_valid = 1'b0;
    drain();
    check("t3_flip_out", last_out, 2'b10);
    check("t3_flip_cnt", o_flip_cnt, 8'd1);
    send(4'h7, 2'b01);
    i_in_valid = 1'b0;
    drain();
    check("t3_pass_out", last_out, 2'b01);
    check("t3_flip_cnt2", o_flip_cnt, 8'd1);

    // 4: backpressure
    i_out_ready = 1'b0;
    i_in_valid = 1'b1; i_x_in = 4'h3; i_prot_in = 2'b10;
    step();
    i_x_in = 4'hF; i_prot_in = 2'b01;
    check("bp_ready_one_full", o_in_ready, 1'b1);
    step();
    i_x_in = 4'h5; i_prot_in = 2'b11;
    check("bp_ready_full", o_in_ready, 1'b0);
    check("bp_out_valid", o_out_valid, 1'b1);
    check("bp_dout", o_data_out, 2'b10);
    step();
    check("bp_ready_hold", o_in_ready, 1'b0);
    check("bp_dout_hold", o_data_out, 2'b10);
    check("bp_accepted", exp_q.size(), 2);
    step();
    check("bp_dout_hold2", o_data_out, 2'b10);
    i_out_ready = 1'b1;
    send(4'h5, 2'b11);
    i_in_valid = 1'b0;
    drain();
    check("bp_last_out", last_out, 2'b11);
    check("bp_flip_cnt", o_flip_cnt, 8'd2);

    // 5: reload mid-stream, then key_start+key_valid clash
    i_out_ready = 1'b0;
    i_in_valid = 1'b1; i_x_in = 4'hF; i_prot_in = 2'b00;
    step();
    i_x_in = 4'h1;
    step();
    i_in_valid = 1'b0;
    check("rl_v2_full", o_out_valid, 1'b1);
    i_key_start = 1'b1;
    exp_q.delete();
    acc_q.delete();
    step();
    i_key_start = 1'b0;
    check("rl_out_valid", o_out_valid, 1'b0);
    check("rl_key_loaded", o_key_loaded, 1'b0);
    check("rl_in_ready", o_in_ready, 1'b0);
    check("rl_flip_kept", o_flip_cnt, 8'd3);
    i_out_ready = 1'b1;
    load_key(8'hF0, 1'b1);
    i_key_valid = 1'b1; i_key_bit = 1'b1;
    step(); step(); step();
    i_key_valid = 1'b0;
    check("armed_ignores_bits", o_key_loaded, 1'b1);
    send(4'hF, 2'b01);
    send(4'hE, 2'b11);
    i_in_valid = 1'b0;
    drain();
    check("rl_last_out", last_out, 2'b11);
    check("rl_flip_cnt", o_flip_cnt, 8'd4);

    // 6: saturation on the 2-bit counter instance
    i_rst = 1'b1;
    step(); step();
    i_rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check("sat_rst_cnt", s_flip_cnt, 2'd0);
    check("sat_rst_main_cnt", o_flip_cnt, 8'd0);
    load_key(8'hF0, 1'b0);
    check("sat_key_loaded", s_key_loaded, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(4'hF, 2'b00);
      i_in_valid = 1'b0;
      drain();
      check("sat_cnt", s_flip_cnt, (i < 2) ? i + 1 : 3);
      check("sat_main_cnt", o_flip_cnt, i + 1);
    end
    check("sat_dout", s_data_out, 2'b11);
    step(); step(); step();
    check("sat_cnt_stays", s_flip_cnt, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
